// File: rtl/rc_route_xy_pipe.sv
// rtl/rc_route_xy_pipe.sv - mesh route computation stage with packet tracking and 1-entry output register
// Optional: RC_ERR_CNT_EN adds a saturating err_cnt[7:0] output.
module rc_route_xy_pipe #(
  parameter int DATASIZE    = 30,
  parameter int MESH_X      = 5,
  parameter int MESH_Y      = 4,
  parameter int router_ID   = 6,
  parameter int DST_LSB     = 20,
  parameter int DST_W       = 5,
  parameter int TYPE_LSB    = 28,
  parameter int ROUTE_ORDER = 0
) (
  input  logic                rc_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  output logic [4:0]          direction_out,
  input  logic                rc_ready,
  output logic                err_out
`ifdef RC_ERR_CNT_EN
  ,
  output logic [7:0]          err_cnt
`endif
);

  localparam int CX = router_ID % MESH_X;
  localparam int CY = router_ID / MESH_X;

  localparam logic [1:0] FT_SINGLE = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_BODY   = 2'b10;

  typedef enum logic {IDLE, PKT} state_t;

  state_t              state_q, state_d;
  logic [4:0]          route_q, route_d;
  logic [DATASIZE-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic [4:0]          dir_q, dir_d;
  logic                err_q, err_d;

  logic [1:0] ftype;
  logic       accept;
  logic [4:0] route_calc;
  logic       route_bad;
  int         dst_i;
  int         dx;
  int         dy;

  assign ftype     = data_in[TYPE_LSB +: 2];
  assign ready_out = !valid_q || rc_ready;
  assign accept    = valid_in && ready_out;

  // One-hot {W,S,E,N,Local}: b1 y-1, b2 x+1, b3 y+1, b4 x-1.
  always_comb begin
    route_calc = 5'b00000;
    route_bad  = 1'b0;
    dst_i      = int'(data_in[DST_LSB +: DST_W]);
    dx         = dst_i % MESH_X;
    dy         = dst_i / MESH_X;
    if (dst_i >= MESH_X * MESH_Y) begin
      route_bad = 1'b1;
    end else if (ROUTE_ORDER == 0) begin
      if (dy < CY)      route_calc = 5'b00010;
      else if (dy > CY) route_calc = 5'b01000;
      else if (dx > CX) route_calc = 5'b00100;
      else if (dx < CX) route_calc = 5'b10000;
      else              route_calc = 5'b00001;
    end else begin
      if (dx > CX)      route_calc = 5'b00100;
      else if (dx < CX) route_calc = 5'b10000;
      else if (dy < CY) route_calc = 5'b00010;
      else if (dy > CY) route_calc = 5'b01000;
      else              route_calc = 5'b00001;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    data_d  = data_q;
    valid_d = valid_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    if (accept) begin
      data_d  = data_in;
      valid_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (ftype == FT_SINGLE) begin
            dir_d = route_calc;
            err_d = route_bad;
          end else if (ftype == FT_HEAD) begin
            dir_d   = route_calc;
            route_d = route_calc;
            err_d   = route_bad;
            state_d = PKT;
          end else begin
            dir_d = 5'b00000;
            err_d = 1'b1;
          end
        end
        default: begin
          // A head/single inside a packet is routed as new traffic but flagged.
          if (ftype == FT_BODY) begin
            dir_d = route_q;
          end else if (ftype == FT_HEAD) begin
            dir_d   = route_calc;
            route_d = route_calc;
            err_d   = 1'b1;
          end else if (ftype == FT_SINGLE) begin
            dir_d   = route_calc;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            dir_d   = route_q;
            state_d = IDLE;
          end
        end
      endcase
    end else if (valid_q && rc_ready) begin
      valid_d = 1'b0;
      dir_d   = 5'b00000;
    end
  end

  always_ff @(posedge rc_clk) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= 5'b00000;
      data_q  <= '0;
      valid_q <= 1'b0;
      dir_q   <= 5'b00000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign direction_out = dir_q;
  assign err_out       = err_q;

`ifdef RC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge rc_clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_rc_route_xy_pipe.sv
// tb/tb_rc_route_xy_pipe.sv - table-driven scoreboard bench for rc_route_xy_pipe
module tb_rc_route_xy_pipe;

  localparam int DW = 30;

  typedef struct {
    logic [1:0] t;
    int         dst;
    logic [4:0] dir;
    logic       err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [4:0]    dir;
    logic          err;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [4:0]    direction_out;
  logic          rc_ready;
  logic          err_out;

  logic [DW-1:0] x_data_in;
  logic          x_valid_in;
  logic          x_ready_out;
  logic [DW-1:0] x_data_out;
  logic          x_valid_out;
  logic [4:0]    x_direction_out;
  logic          x_rc_ready;
  logic          x_err_out;

`ifdef RC_ERR_CNT_EN
  logic [7:0] err_cnt;
  logic [7:0] x_err_cnt;
`endif

  int   n_vec;
  int   n_fail;
  exp_t sb[$];
  exp_t cur_exp;
  logic err_pend;
  vec_t vt[$];

  rc_route_xy_pipe dut (
    .rc_clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .direction_out(direction_out), .rc_ready(rc_ready), .err_out(err_out)
`ifdef RC_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  rc_route_xy_pipe #(.ROUTE_ORDER(1)) dut_xy (
    .rc_clk(clk), .rst(rst), .data_in(x_data_in), .valid_in(x_valid_in),
    .ready_out(x_ready_out), .data_out(x_data_out), .valid_out(x_valid_out),
    .direction_out(x_direction_out), .rc_ready(x_rc_ready), .err_out(x_err_out)
`ifdef RC_ERR_CNT_EN
    , .err_cnt(x_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_flit(input logic [1:0] t, input int dst);
    logic [DW-1:0] d;
    d = '0;
    d[29:28] = t;
    d[24:20] = 5'(dst);
    d[19:0]  = 20'($urandom);
    return d;
  endfunction

  // Scoreboard: push on accept, pop on downstream transfer; err_out checked the cycle after accept.
  always @(negedge clk) begin
    exp_t e;
    chk("err_out", {31'd0, err_out}, {31'd0, err_pend});
    if (valid_out && rc_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", {31'd0, valid_out}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("data_out", {2'b00, data_out}, {2'b00, e.data});
        chk("direction_out", {27'd0, direction_out}, {27'd0, e.dir});
      end
    end
    if (rst) begin
      sb.delete();
      err_pend = 1'b0;
    end else if (valid_in && ready_out) begin
      sb.push_back(cur_exp);
      err_pend = cur_exp.err;
    end else begin
      err_pend = 1'b0;
    end
  end

  task automatic send(input logic [1:0] t, input int dst, input logic [4:0] dir, input logic err);
    logic [DW-1:0] d;
    int n;
    d = mk_flit(t, dst);
    cur_exp.data = d;
    cur_exp.dir  = dir;
    cur_exp.err  = err;
    data_in  = d;
    valid_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_out && n < 50);
    if (!ready_out) chk("accept_timeout", {31'd0, ready_out}, 32'd1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] held;
    int n_err_exp;
    n_vec = 0;
    n_fail = 0;
    err_pend = 1'b0;
    rst = 1'b1;
    data_in = '0;
    valid_in = 1'b0;
    rc_ready = 1'b1;
    x_data_in = '0;
    x_valid_in = 1'b0;
    x_rc_ready = 1'b1;
    cur_exp.data = '0;
    cur_exp.dir = 5'b0;
    cur_exp.err = 1'b0;

    // router 6 sits at (1,1); YX order
    vt.push_back(vec_t'{2'b10, 3,  5'b00000, 1'b1});
    vt.push_back(vec_t'{2'b00, 25, 5'b00000, 1'b1});
    vt.push_back(vec_t'{2'b00, 0,  5'b00010, 1'b0});
    vt.push_back(vec_t'{2'b00, 5,  5'b10000, 1'b0});
    vt.push_back(vec_t'{2'b00, 6,  5'b00001, 1'b0});
    vt.push_back(vec_t'{2'b00, 7,  5'b00100, 1'b0});
    vt.push_back(vec_t'{2'b00, 12, 5'b01000, 1'b0});
    vt.push_back(vec_t'{2'b00, 19, 5'b01000, 1'b0});
    vt.push_back(vec_t'{2'b00, 1,  5'b00010, 1'b0});
    vt.push_back(vec_t'{2'b00, 10, 5'b01000, 1'b0});
    vt.push_back(vec_t'{2'b00, 20, 5'b00000, 1'b1});
    vt.push_back(vec_t'{2'b00, 31, 5'b00000, 1'b1});
    vt.push_back(vec_t'{2'b01, 12, 5'b01000, 1'b0});
    vt.push_back(vec_t'{2'b10, 0,  5'b01000, 1'b0});
    vt.push_back(vec_t'{2'b10, 31, 5'b01000, 1'b0});
    vt.push_back(vec_t'{2'b11, 7,  5'b01000, 1'b0});
    vt.push_back(vec_t'{2'b00, 5,  5'b10000, 1'b0});
    vt.push_back(vec_t'{2'b01, 7,  5'b00100, 1'b0});
    vt.push_back(vec_t'{2'b01, 5,  5'b10000, 1'b1});
    vt.push_back(vec_t'{2'b10, 12, 5'b10000, 1'b0});
    vt.push_back(vec_t'{2'b11, 0,  5'b10000, 1'b0});
    vt.push_back(vec_t'{2'b01, 12, 5'b01000, 1'b0});
    vt.push_back(vec_t'{2'b00, 0,  5'b00010, 1'b1});
    vt.push_back(vec_t'{2'b10, 6,  5'b00000, 1'b1});
    vt.push_back(vec_t'{2'b11, 6,  5'b00000, 1'b1});
    vt.push_back(vec_t'{2'b00, 11, 5'b01000, 1'b0});
    vt.push_back(vec_t'{2'b00, 8,  5'b00100, 1'b0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_data_out", {2'b00, data_out}, 32'd0);
    chk("rst_direction_out", {27'd0, direction_out}, 32'd0);
    chk("rst_ready_out", {31'd0, ready_out}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    n_err_exp = 0;
    foreach (vt[i]) begin
      send(vt[i].t, vt[i].dst, vt[i].dir, vt[i].err);
      if (vt[i].err) n_err_exp++;
    end
    drain();
`ifdef RC_ERR_CNT_EN
    chk("err_cnt", {24'd0, err_cnt}, n_err_exp);
`endif

    // Downstream stall with input pending: output must hold, nothing lost.
    send(2'b00, 0, 5'b00010, 1'b0);
    held = cur_exp.data;
    rc_ready = 1'b0;
    fork
      begin
        send(2'b00, 5, 5'b10000, 1'b0);
        send(2'b00, 6, 5'b00001, 1'b0);
        send(2'b00, 7, 5'b00100, 1'b0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready_out", {31'd0, ready_out}, 32'd0);
          chk("stall_valid_out", {31'd0, valid_out}, 32'd1);
          chk("stall_data_hold", {2'b00, data_out}, {2'b00, held});
          chk("stall_dir_hold", {27'd0, direction_out}, 32'b00010);
        end
        @(posedge clk);
        #1;
        rc_ready = 1'b1;
      end
    join
    drain();

    // Reset after a head while it is still held: flit and latched route discarded.
    rc_ready = 1'b0;
    send(2'b01, 12, 5'b01000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rc_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("midrst_direction_out", {27'd0, direction_out}, 32'd0);
    @(posedge clk);
    #1;
    send(2'b10, 12, 5'b00000, 1'b1);
    drain();
    chk("sb_empty", sb.size(), 32'd0);

    // XY order instance: X resolved before Y.
    for (int k = 0; k < 4; k++) begin
      int dst;
      logic [4:0] ed;
      case (k)
        0: begin dst = 0;  ed = 5'b10000; end
        1: begin dst = 11; ed = 5'b01000; end
        2: begin dst = 10; ed = 5'b10000; end
        default: begin dst = 2; ed = 5'b00100; end
      endcase
      x_data_in = mk_flit(2'b00, dst);
      x_valid_in = 1'b1;
      @(posedge clk);
      #1;
      x_valid_in = 1'b0;
      @(negedge clk);
      chk("xy_valid_out", {31'd0, x_valid_out}, 32'd1);
      chk("xy_direction_out", {27'd0, x_direction_out}, {27'd0, ed});
      chk("xy_data_out", {2'b00, x_data_out}, {2'b00, x_data_in});
      chk("xy_err_out", {31'd0, x_err_out}, 32'd0);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
